// File: rtl/fsm_experiment_seq.sv
// fsm_experiment_seq: shot sequencer (fg sync, delay, detonation, wire break, detector triggers, fault/abort).
// Define FSM_EXP_TRIG_STAGGER_EN to stagger channel k's trigger by k*TRIG_STEP cycles.
module fsm_experiment_seq #(
   parameter int N_CH          = 4,
   parameter int CNT_W         = 32,
   parameter int FG_DELAY      = 400000,
   parameter int DET_PULSE_LEN = 50,
   parameter int WIRE_TIMEOUT  = 1000000,
   parameter int BUSY_TIMEOUT  = 500,
   parameter int READY_TIMEOUT = 500,
   parameter int TRIG_STEP     = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_signal,
   input  logic             abort,
   input  logic             fg_signal,
   input  logic             wire_signal,
   input  logic [N_CH-1:0]  detector_ready,
   output logic             detonation_signal,
   output logic [N_CH-1:0]  output_trigger,
   output logic [3:0]       scenario_state,
   output logic [CNT_W-1:0] counter_,
   output logic [1:0]       fault_code,
   output logic [N_CH-1:0]  ready_timeout_mask,
   output logic [15:0]      shot_count
);
   typedef enum logic [3:0] {
      IDLE = 4'd0, FG_WAIT = 4'd1, FG_DLY = 4'd2, DETONATE = 4'd3, WIRE_WAIT = 4'd4,
      DET_BUSY = 4'd5, DET_WAIT = 4'd6, FINISHED = 4'd7, FAULT = 4'd8
   } state_t;
`ifdef FSM_EXP_TRIG_STAGGER_EN
   localparam int STEP = TRIG_STEP;
`else
   localparam int STEP = 0 * TRIG_STEP;
`endif
   localparam int STAG = (N_CH - 1) * STEP;
   localparam logic [CNT_W-1:0] FG_END    = CNT_W'(FG_DELAY - 1);
   localparam logic [CNT_W-1:0] DET_END   = CNT_W'(DET_PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] WIRE_END  = CNT_W'(WIRE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BUSY_END  = CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] READY_END = CNT_W'(READY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STAG_END  = CNT_W'(STAG > 0 ? STAG - 1 : 0);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic det, det_n, stag, stag_n;
   logic [N_CH-1:0] trig, trig_n, mask, mask_n, rdy_s1, rdy_s;
   logic [1:0] code, code_n;
   logic [15:0] shots, shots_n;
   logic [3:0] fg_sr;
   logic [1:0] wire_sr;
   logic fg_rise, wire_s;
   assign fg_rise = fg_sr[2] & ~fg_sr[3];
   assign wire_s  = wire_sr[1];
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fg_sr   <= '0;
         wire_sr <= '0;
         rdy_s1  <= '0;
         rdy_s   <= '0;
      end else begin
         fg_sr   <= {fg_sr[2:0], fg_signal};
         wire_sr <= {wire_sr[0], wire_signal};
         rdy_s1  <= detector_ready;
         rdy_s   <= rdy_s1;
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         det   <= 1'b0;
         stag  <= 1'b0;
         trig  <= '0;
         mask  <= '0;
         code  <= '0;
         shots <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         det   <= det_n;
         stag  <= stag_n;
         trig  <= trig_n;
         mask  <= mask_n;
         code  <= code_n;
         shots <= shots_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      det_n   = 1'b0;
      stag_n  = 1'b0;
      trig_n  = trig;
      mask_n  = mask;
      code_n  = code;
      shots_n = shots;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (start_signal) begin
               state_n = FG_WAIT;
               mask_n  = '0;
            end
         end
         FG_WAIT: begin
            cnt_n = '0;
            if (abort) begin
               state_n = FAULT;
               code_n  = 2'd3;
            end else if (fg_rise) state_n = FG_DLY;
         end
         FG_DLY: begin
            if (abort) begin
               state_n = FAULT;
               code_n  = 2'd3;
               cnt_n   = '0;
            end else if (cnt == FG_END) begin
               state_n = DETONATE;
               cnt_n   = '0;
               det_n   = 1'b1;
            end
         end
         DETONATE: begin
            det_n = 1'b1;
            if (cnt == DET_END) begin
               state_n = WIRE_WAIT;
               cnt_n   = '0;
               det_n   = 1'b0;
            end
         end
         WIRE_WAIT: begin
            // stag marks the stagger phase after wire break; the wire timeout no longer applies
            if (stag) begin
               stag_n = 1'b1;
               for (int k = 0; k < N_CH; k++) trig_n[k] = trig[k] | (cnt + 1'b1 == CNT_W'(k * STEP));
               if (cnt == STAG_END) begin
                  state_n = DET_BUSY;
                  stag_n  = 1'b0;
                  cnt_n   = '0;
               end
            end else if (wire_s) begin
               cnt_n   = '0;
               trig_n  = STAG == 0 ? '1 : N_CH'(1);
               stag_n  = STAG != 0;
               state_n = STAG == 0 ? DET_BUSY : WIRE_WAIT;
            end else if (cnt == WIRE_END) begin
               state_n = FAULT;
               code_n  = 2'd1;
               cnt_n   = '0;
            end
         end
         DET_BUSY: begin
            if (~|rdy_s) begin
               state_n = DET_WAIT;
               cnt_n   = '0;
            end else if (cnt == BUSY_END) begin
               state_n = FAULT;
               code_n  = 2'd2;
               trig_n  = '0;
               cnt_n   = '0;
            end
         end
         DET_WAIT: begin
            trig_n = trig & ~rdy_s;
            if (cnt == READY_END) begin
               mask_n = mask | (trig & ~rdy_s);
               trig_n = '0;
            end
            if (~|trig) begin
               state_n = FINISHED;
               shots_n = shots + 1'b1;
               cnt_n   = '0;
            end
         end
         FINISHED: begin
            cnt_n = '0;
            if (!start_signal) state_n = IDLE;
         end
         FAULT: begin
            cnt_n  = '0;
            trig_n = '0;
            if (!start_signal) begin
               state_n = IDLE;
               code_n  = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end
   assign detonation_signal  = det;
   assign output_trigger     = trig;
   assign scenario_state     = state;
   assign counter_           = cnt;
   assign fault_code         = code;
   assign ready_timeout_mask = mask;
   assign shot_count         = shots;
endmodule

// File: tb/tb_fsm_experiment_seq.sv
// tb_fsm_experiment_seq: directed bench for fsm_experiment_seq; u0 is a 2-channel unit, u1 a 4-channel unit with TRIG_STEP=3.
module tb_fsm_experiment_seq;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start_signal = 1'b0, abort = 1'b0, fg_signal = 1'b0, wire_signal = 1'b0;
   logic [1:0] detector_ready = '0;
   logic [3:0] ready4 = '0;
   logic det0, det1, det_seen;
   logic [1:0] trig0, fc0, fc1, mask0;
   logic [3:0] trig1, mask1, st0, st1;
   logic [31:0] cnt0, cnt1;
   logic [15:0] shots0, shots1;
   int errors = 0;
   int checks = 0;
   always #5 clock = ~clock;
   fsm_experiment_seq #(.N_CH(2), .CNT_W(32), .FG_DELAY(10), .DET_PULSE_LEN(5), .WIRE_TIMEOUT(20),
      .BUSY_TIMEOUT(6), .READY_TIMEOUT(8), .TRIG_STEP(0)) u0 (
      .clock(clock), .reset(reset), .start_signal(start_signal), .abort(abort),
      .fg_signal(fg_signal), .wire_signal(wire_signal), .detector_ready(detector_ready),
      .detonation_signal(det0), .output_trigger(trig0), .scenario_state(st0), .counter_(cnt0),
      .fault_code(fc0), .ready_timeout_mask(mask0), .shot_count(shots0));
   fsm_experiment_seq #(.N_CH(4), .CNT_W(32), .FG_DELAY(10), .DET_PULSE_LEN(5), .WIRE_TIMEOUT(20),
      .BUSY_TIMEOUT(6), .READY_TIMEOUT(8), .TRIG_STEP(3)) u1 (
      .clock(clock), .reset(reset), .start_signal(start_signal), .abort(abort),
      .fg_signal(fg_signal), .wire_signal(wire_signal), .detector_ready(ready4),
      .detonation_signal(det1), .output_trigger(trig1), .scenario_state(st1), .counter_(cnt1),
      .fault_code(fc1), .ready_timeout_mask(mask1), .shot_count(shots1));
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      detector_ready = 2'b11;
      ready4 = 4'hF;
      tick(2);
      chk("rst_state", 32'(st0), 0);
      chk("rst_det", 32'(det0), 0);
      chk("rst_trig", 32'(trig0), 0);
      chk("rst_shots", 32'(shots0), 0);
      chk("rst_cnt", cnt0, 0);
      reset = 1'b1;
      tick(2);
      chk("idle_state", 32'(st0), 0);
      // nominal shot; n<k> = k-th falling edge after fg is driven high
      start_signal = 1'b1;
      tick(1);
      chk("nom_s1", 32'(st0), 1);
      fg_signal = 1'b1;
      tick(4);
      chk("nom_s2", 32'(st0), 2);
      chk("nom_cnt0", cnt0, 0);
      fg_signal = 1'b0;
      tick(9);
      chk("nom_cnt9", cnt0, 9);
      chk("nom_det_pre", 32'(det0), 0);
      tick(1);
      chk("nom_s3", 32'(st0), 3);
      chk("nom_det_on", 32'(det0), 1);
      tick(4);
      chk("nom_det_last", 32'(det0), 1);
      tick(1);
      chk("nom_s4", 32'(st0), 4);
      chk("nom_det_off", 32'(det0), 0);
      wire_signal = 1'b1;
      tick(2);
      chk("nom_trig_pre", 32'(trig0), 0);
      tick(1);
      chk("nom_s5", 32'(st0), 5);
      chk("nom_trig_on", 32'(trig0), 3);
      detector_ready = 2'b00;
      tick(3);
      chk("nom_s6", 32'(st0), 6);
      detector_ready = 2'b11;
      wire_signal = 1'b0;
      tick(3);
      chk("nom_trig_off", 32'(trig0), 0);
      tick(1);
      chk("nom_s7", 32'(st0), 7);
      chk("nom_shots", 32'(shots0), 1);
      start_signal = 1'b0;
      tick(1);
      chk("nom_s0", 32'(st0), 0);
      // partial ready: ch1 stays busy until READY_TIMEOUT
      start_signal = 1'b1;
      tick(1);
      fg_signal = 1'b1;
      tick(4);
      fg_signal = 1'b0;
      tick(15);
      wire_signal = 1'b1;
      tick(3);
      detector_ready = 2'b00;
      tick(3);
      chk("prt_s6", 32'(st0), 6);
      detector_ready = 2'b01;
      wire_signal = 1'b0;
      tick(3);
      chk("prt_trig_ch0", 32'(trig0), 2);
      tick(4);
      chk("prt_trig_hold", 32'(trig0), 2);
      chk("prt_mask_pre", 32'(mask0), 0);
      tick(1);
      chk("prt_trig_to", 32'(trig0), 0);
      chk("prt_mask", 32'(mask0), 2);
      tick(1);
      chk("prt_s7", 32'(st0), 7);
      chk("prt_shots", 32'(shots0), 2);
      start_signal = 1'b0;
      detector_ready = 2'b11;
      tick(1);
      chk("prt_idle_mask", 32'(mask0), 2);
      // wire timeout
      start_signal = 1'b1;
      tick(1);
      chk("mask_clr", 32'(mask0), 0);
      fg_signal = 1'b1;
      tick(4);
      fg_signal = 1'b0;
      tick(15);
      chk("wto_s4", 32'(st0), 4);
      tick(19);
      chk("wto_last", 32'(st0), 4);
      chk("wto_cnt", cnt0, 19);
      tick(1);
      chk("wto_s8", 32'(st0), 8);
      chk("wto_code", 32'(fc0), 1);
      chk("wto_trig", 32'(trig0), 0);
      tick(5);
      chk("wto_hold", 32'(fc0), 1);
      start_signal = 1'b0;
      tick(1);
      chk("wto_idle", 32'(st0), 0);
      chk("wto_code_clr", 32'(fc0), 0);
      // abort in FG_DLY at counter 3
      start_signal = 1'b1;
      tick(1);
      fg_signal = 1'b1;
      tick(4);
      fg_signal = 1'b0;
      tick(3);
      chk("abt_cnt3", cnt0, 3);
      abort = 1'b1;
      tick(1);
      chk("abt_s8", 32'(st0), 8);
      chk("abt_code", 32'(fc0), 3);
      det_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         det_seen = det_seen | det0;
      end
      chk("abt_no_det", 32'(det_seen), 0);
      abort = 1'b0;
      start_signal = 1'b0;
      tick(1);
      chk("abt_idle", 32'(st0), 0);
      // abort ignored in DETONATE, then asynchronous reset mid-pulse
      start_signal = 1'b1;
      tick(1);
      fg_signal = 1'b1;
      tick(4);
      fg_signal = 1'b0;
      tick(10);
      abort = 1'b1;
      tick(2);
      chk("abd_s3", 32'(st0), 3);
      chk("abd_det", 32'(det0), 1);
      chk("abd_code", 32'(fc0), 0);
      #2 reset = 1'b0;
      #1;
      chk("mrst_det", 32'(det0), 0);
      chk("mrst_state", 32'(st0), 0);
      chk("mrst_shots", 32'(shots0), 0);
      chk("mrst_code", 32'(fc0), 0);
      chk("mrst_trig", 32'(trig0), 0);
      abort = 1'b0;
      start_signal = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(2);
      // four-channel unit: trigger stagger, then busy timeout since its detectors never go busy
      start_signal = 1'b1;
      tick(1);
      fg_signal = 1'b1;
      tick(4);
      fg_signal = 1'b0;
      tick(15);
      wire_signal = 1'b1;
      tick(2);
      chk("stg_pre", 32'(trig1), 0);
      tick(1);
`ifdef FSM_EXP_TRIG_STAGGER_EN
      chk("stg_ch0", 32'(trig1), 4'b0001);
      tick(3);
      chk("stg_ch1", 32'(trig1), 4'b0011);
      tick(3);
      chk("stg_ch2", 32'(trig1), 4'b0111);
      chk("stg_s4", 32'(st1), 4);
      tick(3);
      chk("stg_ch3", 32'(trig1), 4'b1111);
`else
      chk("stg_all", 32'(trig1), 4'b1111);
`endif
      chk("stg_s5", 32'(st1), 5);
      tick(5);
      chk("bto_last", 32'(st1), 5);
      chk("bto_cnt", cnt1, 5);
      tick(1);
      chk("bto_s8", 32'(st1), 8);
      chk("bto_code", 32'(fc1), 2);
      chk("bto_trig", 32'(trig1), 0);
      wire_signal = 1'b0;
      start_signal = 1'b0;
      tick(1);
      chk("bto_idle", 32'(st1), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
